// File: rtl/iic_defs.sv
// Shared I2C definitions: FSM state encoding and default target address,
// common to the slave and master sides.
package iic_defs;

  localparam logic [6:0] IIC_DEV_ADDR = 7'h50;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    WADDR,
    WADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RD_MACK
  } iic_state_e;

endpackage

// File: rtl/iic_sync_edge.sv
// Two-flop synchronizer plus one history stage with rise/fall detection.
// Flops reset to 1 to match an idle (pulled-up) I2C line.
module iic_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  // shift the pin through two metastability stages and one history stage
  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  // synchronizer register, idle-high after reset
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/iic_slave_mem.sv
// I2C target with a byte-wide memory: address phase, word-address pointer,
// sequential write and sequential read with auto-increment.
module iic_slave_mem
  import iic_defs::*;
#(
  parameter logic [6:0]  DEV_ADDR = IIC_DEV_ADDR,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic              busy,
  output logic              wr_pulse,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_sync_edge u_scl_sync (
    .clk   (clk_50M),
    .rst   (rst),
    .din   (scl),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  iic_sync_edge u_sda_sync (
    .clk   (clk_50M),
    .rst   (rst),
    .din   (sda),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  iic_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        tx_q, tx_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              phase_q, phase_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              mem_we;
  logic [7:0]        rx_byte;
  logic [7:0]        mem_rd;

  logic [7:0] mem [DEPTH];

  assign mem_rd = mem[ptr_q];

  // next-state logic; START/STOP override any bit activity in the same clock.
  // phase_q: in *_ACK states 0 = waiting to pull ACK, 1 = waiting to release;
  // in RD_MACK 1 = master acknowledged, next byte loads on the coming fall.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    rx_byte    = {shift_q[6:0], sda_lvl};

    if (start_det) begin
      state_d   = DEV;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        DEV, WADDR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (state_q == DEV) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = DEV_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IDLE;
                end
              end else if (state_q == WADDR) begin
                ptr_d   = MEM_AW'(rx_byte);
                state_d = WADDR_ACK;
              end else begin
                state_d = WDATA_ACK;
              end
            end
          end
        end

        DEV_ACK, WADDR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sda_oe_d = 1'b1;
              if (state_q == WDATA_ACK) begin
                mem_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = shift_q;
                ptr_d      = ptr_q + MEM_AW'(1);
              end
            end else begin
              phase_d   = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == DEV_ACK && rw_q) begin
                state_d  = RDATA;
                tx_d     = {mem_rd[6:0], 1'b0};
                sda_oe_d = ~mem_rd[7];
              end else if (state_q == DEV_ACK) begin
                state_d = WADDR;
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + MEM_AW'(1);
              phase_d  = 1'b0;
              state_d  = RD_MACK;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
            end
          end
        end

        RD_MACK: begin
          if (scl_rise) begin
            if (sda_lvl) state_d = IDLE;
            else         phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            bit_cnt_d = '0;
            tx_d      = {mem_rd[6:0], 1'b0};
            sda_oe_d  = ~mem_rd[7];
            state_d   = RDATA;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // control and status registers
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // memory array, intentionally not reset
  always_ff @(posedge clk_50M) begin
    if (mem_we) mem[ptr_q] <= shift_q;
  end

  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_iic_slave_mem.sv
// Bench for iic_slave_mem: bit-banged I2C master, reference memory model.
`timescale 1ns/1ps
module tb_iic_slave_mem;

  localparam int unsigned Q = 5;  // clk_50M cycles per quarter scl period

  logic       clk_50M = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       busy;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #10 clk_50M = ~clk_50M;

  iic_slave_mem #(.DEV_ADDR(7'h50), .MEM_AW(8)) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int exp_wr  = 0;

  logic [7:0]  ref_mem [256];
  int unsigned ref_ptr;
  logic [7:0]  wbuf [8];

  always @(negedge clk_50M) if (wr_pulse === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk_50M);
  endtask

  // works from idle (scl high) or mid-transfer (scl low) as a repeated START
  task automatic i2c_start();
    m_low = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    m_low = 1'b1; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    m_low = 1'b0; wait_q();
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      m_low = ~b[7 - i]; wait_q();
      scl   = 1'b1;      wait_q(); wait_q();
      scl   = 1'b0;      wait_q();
    end
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    m_low = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    ack   = sda;  wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    m_low = 1'b0;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      wait_q();
      scl = 1'b1; wait_q();
      b   = {b[6:0], sda}; wait_q();
      scl = 1'b0;
    end
    wait_q();
    m_low = ~nack; wait_q();
    scl   = 1'b1;  wait_q(); wait_q();
    scl   = 1'b0;  wait_q();
    m_low = 1'b0;
  endtask

  // full write transaction of n bytes from wbuf starting at word address a
  task automatic write_txn(input logic [7:0] a, input int unsigned n);
    logic ack;
    i2c_start();
    wbyte(8'hA0, ack); check("w_dev_ack", ack, 0);
    check("w_busy", busy, 1);
    wbyte(a, ack);     check("w_addr_ack", ack, 0);
    ref_ptr = a;
    for (int unsigned i = 0; i < n; i++) begin
      wbyte(wbuf[i], ack); check("w_data_ack", ack, 0);
      ref_mem[ref_ptr] = wbuf[i];
      ref_ptr = (ref_ptr + 1) % 256;
      exp_wr++;
    end
    i2c_stop();
    check("w_cnt", wr_cnt, exp_wr);
    check("w_last_addr", wr_addr, (ref_ptr + 255) % 256);
    check("w_last_data", wr_data, wbuf[n - 1]);
    check("w_busy_off", busy, 0);
  endtask

  // read m bytes after the address phase has already completed
  task automatic read_body(input int unsigned m);
    logic [7:0] b;
    for (int unsigned i = 0; i < m; i++) begin
      rbyte(i == m - 1, b);
      check("rd_byte", b, ref_mem[ref_ptr]);
      ref_ptr = (ref_ptr + 1) % 256;
    end
    check("rd_released", sda, 1);
    i2c_stop();
  endtask

  task automatic read_txn(input logic [7:0] a, input int unsigned m);
    logic ack;
    i2c_start();
    wbyte(8'hA0, ack); check("r_dev_ack", ack, 0);
    wbyte(a, ack);     check("r_addr_ack", ack, 0);
    ref_ptr = a;
    i2c_start();
    wbyte(8'hA1, ack); check("r_rd_ack", ack, 0);
    read_body(m);
  endtask

  task automatic cur_read(input int unsigned m);
    logic ack;
    i2c_start();
    wbyte(8'hA1, ack); check("c_rd_ack", ack, 0);
    read_body(m);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] a;
    int unsigned n, off, m;

    rst = 1'b1; scl = 1'b1; m_low = 1'b0; ref_ptr = 0;
    repeat (5) @(negedge clk_50M);
    check("rst_busy", busy, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sda", sda, 1);
    rst = 1'b0;
    wait_q();

    // single byte write
    wbuf[0] = 8'h5A;
    write_txn(8'h10, 1);
    check("bw_addr", wr_addr, 8'h10);
    check("bw_data", wr_data, 8'h5A);

    // page write wrapping past the top of memory, then sequential read back
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    write_txn(8'hFE, 3);
    check("wrap_addr", wr_addr, 8'h00);
    read_txn(8'hFE, 3);

    // wrong device address: no ACK, not busy, further bytes ignored
    i2c_start();
    wbyte(8'hA2, ack); check("bad_nack", ack, 1);
    check("bad_busy", busy, 0);
    wbyte(8'h00, ack); check("bad_byte1", ack, 1);
    wbyte(8'h77, ack); check("bad_byte2", ack, 1);
    i2c_stop();
    check("bad_wr_cnt", wr_cnt, exp_wr);

    // reset while the slave drives a 0 bit of mem[0x00]
    i2c_start();
    wbyte(8'hA0, ack); check("mr_dev_ack", ack, 0);
    wbyte(8'h00, ack); check("mr_addr_ack", ack, 0);
    i2c_start();
    wbyte(8'hA1, ack); check("mr_rd_ack", ack, 0);
    check("mr_bit7_low", sda, 0);
    rst = 1'b1;
    @(negedge clk_50M);
    check("mr_released", sda, 1);
    rst = 1'b0;
    ref_ptr = 0;
    wait_q();
    cur_read(1);

    // STOP inside WDATA after 4 bits: no write, pointer unchanged
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom); wbuf[2] = 8'($urandom);
    write_txn(8'h40, 3);
    a = 8'($urandom);
    i2c_start();
    wbyte(8'hA0, ack); check("ab_dev_ack", ack, 0);
    wbyte(8'h40, ack); check("ab_addr_ack", ack, 0);
    wbyte(a, ack);     check("ab_data_ack", ack, 0);
    ref_mem[8'h40] = a; ref_ptr = 8'h41; exp_wr++;
    send_bits(8'($urandom), 4);
    i2c_stop();
    check("ab_wr_cnt", wr_cnt, exp_wr);
    check("ab_busy", busy, 0);
    cur_read(1);
    read_txn(8'h40, 3);

    // randomized write/read-back transactions
    for (int t = 0; t < 8; t++) begin
      a = 8'($urandom);
      n = $urandom_range(1, 4);
      for (int unsigned i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_txn(a, n);
      off = $urandom_range(0, n - 1);
      m   = $urandom_range(1, n - off);
      read_txn(8'((int'(a) + int'(off)) % 256), m);
      if (ref_mem[ref_ptr] !== 8'hxx && ($urandom_range(0, 1) == 1) && ref_ptr != int'(a) + int'(n))
        cur_read(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_slave_mem.md
IIC_SLAVE_MEM -- requirements
Module: iic_slave_mem

Interface
REQ-001 The block SHALL have a parameter DEV_ADDR, default 7'h50, giving the 7-bit I2C target address the block responds to.
REQ-002 The block SHALL have a parameter MEM_AW, default 8, giving the word-address width; memory depth is 2**MEM_AW bytes.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk_50M input 1 system clock; rst input 1 synchronous active-high reset.
REQ-004 The block SHALL have port scl, input, 1 bit: I2C clock from the master.
REQ-005 The block SHALL have port sda, inout, 1 bit: I2C data; the block drives only 0 or 'z', never 1.
REQ-006 The block SHALL have port busy, output, 1 bit: high from an address-matched START until the next STOP or START.
REQ-007 The block SHALL have port wr_pulse, output, 1 bit: one-clock strobe when a data byte is committed to memory.
REQ-008 The block SHALL have ports wr_addr and wr_data, output, MEM_AW and 8 bits: address and byte of the last commit, valid while wr_pulse is high and held afterwards.

Function
REQ-009 The block SHALL pass scl and sda through 2-flop synchronizers plus one history stage; an edge SHALL be detected 3 clk_50M cycles after the pin changes; the design SHALL assume f(clk_50M) >= 16 x f(scl).
REQ-010 The block SHALL treat sda falling while scl is high as START, and sda rising while scl is high as STOP, in any state.
REQ-011 The FSM SHALL have the states IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA and RD_MACK.
REQ-012 START SHALL force the FSM to DEV with the bit count at 0, including repeated START mid-transfer; STOP SHALL force IDLE.
REQ-013 Received bits SHALL be sampled MSB first on scl rising edges; bit count 0..7 SHALL wrap after the 8th bit.
REQ-014 In DEV, after 8 bits, if bits[7:1]==DEV_ADDR the FSM SHALL go to DEV_ACK; on a mismatch it SHALL go to IDLE with sda released and no ACK driven.
REQ-015 ACK SHALL be driven by pulling sda low on the scl falling edge after the 8th rising edge, and released on the next scl falling edge.
REQ-016 After DEV_ACK, R/W=0 SHALL lead to WADDR; R/W=1 SHALL lead to RDATA using the current pointer.
REQ-017 The WADDR byte SHALL load the pointer (low MEM_AW bits), and the FSM SHALL then ACK and go to WDATA.
REQ-018 Each WDATA byte SHALL be written to mem[pointer] in the same clock as the ACK pull-down begins; wr_pulse SHALL be high for that clock; the pointer SHALL then increment modulo 2**MEM_AW.
REQ-019 In RDATA, the block SHALL load mem[pointer] at the scl falling edge that ends the ACK (or ends the previous RD_MACK), drive bit 7 immediately, and drive subsequent bits on each scl falling edge; a 1 bit SHALL release sda.
REQ-020 After 8 read bits, the block SHALL release sda, increment the pointer modulo depth, and sample the master ACK at the 9th scl rising edge: ACK (0) SHALL lead to RDATA, NACK (1) SHALL lead to IDLE.
REQ-021 Random read (write WADDR, repeated START, read) SHALL return mem[WADDR].
REQ-022 The block SHALL ignore scl edges in IDLE; START and STOP detection SHALL take priority over bit sampling in the same clock.

Reset
REQ-023 Reset SHALL set: FSM to IDLE, sda released, busy=0, wr_pulse=0, wr_addr=0, wr_data=0, pointer=0, bit count=0, synchronizers to 1.
REQ-024 Memory contents SHALL NOT be reset; reset mid-transfer SHALL release sda within 1 clock and abandon the transfer.

Structure
REQ-025 The FSM state encoding and the default DEV_ADDR SHALL be placed in a shared include/package, iic_defs, for reuse with the master side.
REQ-026 The block SHALL contain one sub-module, iic_sync_edge, implementing the 2-flop synchronizer with rise/fall detection, instantiated for scl and sda; the memory SHALL be an inferred array in the top level.

Verification
REQ-027 Byte write: START, 0xA0, 0x10, 0x5A, STOP -> three ACKs; wr_pulse once with wr_addr=0x10 and wr_data=0x5A.
REQ-028 Page write with wrap: address 0xFE, data 0x11 0x22 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33.
REQ-029 Random sequential read: write addr 0xFE, repeated START, 0xA1, read 3 bytes with ACK, ACK, NACK -> 0x11 0x22 0x33, then IDLE.
REQ-030 Wrong address: START, 0xA2 -> no ACK (sda stays 'z' on the 9th clock), busy=0, and following bytes are ignored.
REQ-031 Reset mid-read: assert rst while a 0x00 bit is being driven -> sda released the next clock; a subsequent current-address read returns mem[0x00].
REQ-032 STOP inside WDATA after 4 bits -> no write, FSM in IDLE, and the pointer is unchanged.
